pc_redirect_unit: RTL and testbench

- Program-counter and fetch-redirect stage, directly downstream of the branch decision logic.
- Consumes the EX-stage taken/not-taken decision (branch_or_not), the branch or jump target, and jump-register requests.
- Holds the PC register, selects the next PC, and generates IF/ID and ID/EX flushes on redirect.
- Sequences stall and halt, and keeps a saturating count of taken redirects for debug.

---
 rtl/pc_redirect_unit_if.sv | 38 +++
 rtl/pc_redirect_unit.sv | 96 +++++++++
 tb/tb_pc_redirect_unit.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/pc_redirect_unit_if.sv
// pc_redirect_unit_if
//   Bundle between the EX-stage branch logic, the hazard unit and the
//   PC/redirect stage.
//   master : branch/hazard side. Drives the decision, targets, stall and halt.
//            Observes the PC, the flushes, the halted flag and the redirect count.
//   slave  : pc_redirect_unit. Sees the same signals in the opposite direction.
//   Inputs to the unit : stall, ex_valid, branch_or_not, branch_target,
//                        jr, jr_target, halt
//   Outputs of the unit: pc, pc_plus4, flush_ifid, flush_idex, halted,
//                        taken_count
interface pc_redirect_unit_if #(
    parameter int PC_WIDTH  = 32,
    parameter int CNT_WIDTH = 16
);
    logic                 stall;
    logic                 ex_valid;
    logic                 branch_or_not;
    logic [PC_WIDTH-1:0]  branch_target;
    logic                 jr;
    logic [PC_WIDTH-1:0]  jr_target;
    logic                 halt;
    logic [PC_WIDTH-1:0]  pc;
    logic [PC_WIDTH-1:0]  pc_plus4;
    logic                 flush_ifid;
    logic                 flush_idex;
    logic                 halted;
    logic [CNT_WIDTH-1:0] taken_count;

    modport master (
        output stall, ex_valid, branch_or_not, branch_target, jr, jr_target, halt,
        input  pc, pc_plus4, flush_ifid, flush_idex, halted, taken_count
    );

    modport slave (
        input  stall, ex_valid, branch_or_not, branch_target, jr, jr_target, halt,
        output pc, pc_plus4, flush_ifid, flush_idex, halted, taken_count
    );
endinterface

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit
//   Holds the fetch PC and picks the next one. It redirects on EX-stage taken
//   branches and jumps. It flushes IF/ID and ID/EX on each redirect. It holds
//   the PC on stall and on halt. It keeps a saturating count of redirects.
//   clk   : system clock. All state changes on the rising edge.
//   reset : asynchronous, active-high. Loads RESET_PC and returns to RUN.
//   bus   : pc_redirect_unit_if.slave (decision/targets in; pc/flushes/status out)
module pc_redirect_unit #(
    parameter int                PC_WIDTH  = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter int                CNT_WIDTH = 16
) (
    input  logic                clk,
    input  logic                reset,
    pc_redirect_unit_if.slave   bus
);
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [PC_WIDTH-1:0]  r_pc;
    logic [PC_WIDTH-1:0]  w_pc_next;
    logic [PC_WIDTH-1:0]  w_pc_plus4;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_next;
    logic                 w_redirect;

    assign w_pc_plus4 = r_pc + PC_WIDTH'(4);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state and next-PC selection. A redirect outranks stall and halt.
    // Any halt seen together with a redirect is on the wrong path and is dropped.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_redirect   = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_redirect = bus.ex_valid & (bus.jr | bus.branch_or_not);
                if (bus.ex_valid && bus.jr) begin
                    // jalr targets are forced to an even address.
                    w_pc_next = {bus.jr_target[PC_WIDTH-1:1], 1'b0};
                end else if (bus.ex_valid && bus.branch_or_not) begin
                    w_pc_next = bus.branch_target;
                end else if (bus.stall) begin
                    w_pc_next = r_pc;
                end else if (bus.halt) begin
                    w_pc_next    = r_pc;
                    w_state_next = ST_HALT;
                end else begin
                    w_pc_next = w_pc_plus4;
                end
            end
            ST_HALT: begin
                // Frozen until reset. Every input is ignored here.
                w_pc_next    = r_pc;
                w_state_next = ST_HALT;
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    // The counter sticks at all-ones instead of wrapping.
    always_comb begin
        w_cnt_next = r_cnt;
        if (w_redirect && (r_cnt != {CNT_WIDTH{1'b1}})) begin
            w_cnt_next = r_cnt + CNT_WIDTH'(1);
        end
    end

    // The flushes are combinational. The wrong-path instructions in IF/ID and
    // ID/EX die at the same edge that loads the target. The flushes are held
    // low while reset is asserted, even if EX inputs look like a redirect.
    assign bus.flush_ifid  = w_redirect & ~reset;
    assign bus.flush_idex  = w_redirect & ~reset;
    assign bus.pc          = r_pc;
    assign bus.pc_plus4    = w_pc_plus4;
    assign bus.halted      = (r_state == ST_HALT);
    assign bus.taken_count = r_cnt;
endmodule

// File: tb/tb_pc_redirect_unit.sv
module tb_pc_redirect_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pc_redirect_unit_if #(.PC_WIDTH(32), .CNT_WIDTH(16)) bus ();
    pc_redirect_unit_if #(.PC_WIDTH(32), .CNT_WIDTH(2))  bus2 ();

    // Both units see identical stimulus. The second one checks 2-bit saturation.
    assign bus2.stall         = bus.stall;
    assign bus2.ex_valid      = bus.ex_valid;
    assign bus2.branch_or_not = bus.branch_or_not;
    assign bus2.branch_target = bus.branch_target;
    assign bus2.jr            = bus.jr;
    assign bus2.jr_target     = bus.jr_target;
    assign bus2.halt          = bus.halt;

    pc_redirect_unit #(.PC_WIDTH(32), .RESET_PC(32'h0), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave));
    pc_redirect_unit #(.PC_WIDTH(32), .RESET_PC(32'h0), .CNT_WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2.slave));

    int n_total = 0;
    int n_pass  = 0;

    // Reference model, kept in terms of the architectural rules.
    logic [31:0] m_pc;
    bit          m_halt;
    int          m_cnt;
    int          m_cnt2;

    function automatic void model_reset();
        m_pc = 32'h0; m_halt = 0; m_cnt = 0; m_cnt2 = 0;
    endfunction

    function automatic bit model_redirect();
        return !m_halt && bus.ex_valid && (bus.jr || bus.branch_or_not);
    endfunction

    function automatic void model_advance();
        bit red;
        red = model_redirect();
        if (m_halt) return;
        if (bus.ex_valid && bus.jr)                 m_pc = bus.jr_target & 32'hFFFF_FFFE;
        else if (bus.ex_valid && bus.branch_or_not) m_pc = bus.branch_target;
        else if (bus.stall)                         m_pc = m_pc;
        else if (bus.halt)                          m_halt = 1;
        else                                        m_pc = m_pc + 32'd4;
        if (red) begin
            m_cnt  = (m_cnt  < 65535) ? m_cnt + 1  : 65535;
            m_cnt2 = (m_cnt2 < 3)     ? m_cnt2 + 1 : 3;
        end
    endfunction

    task automatic drive(input bit ev, input bit bor, input logic [31:0] bt,
                         input bit j, input logic [31:0] jt, input bit st, input bit h);
        @(negedge clk);
        bus.ex_valid = ev; bus.branch_or_not = bor; bus.branch_target = bt;
        bus.jr = j; bus.jr_target = jt; bus.stall = st; bus.halt = h;
    endtask

    // Samples the flushes before the edge, clocks once, then updates the model.
    task automatic tick(output logic fi, output logic fx, output bit red);
        #1;
        fi = bus.flush_ifid; fx = bus.flush_idex; red = model_redirect();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    // Async reset asserted away from any edge, released after an edge.
    task automatic do_reset();
        @(negedge clk); #2; reset = 1'b1;
        model_reset();
        @(posedge clk); #3; reset = 1'b0;
    endtask

    task automatic test_reset();
        logic fi, fx;
        drive(1, 1, 32'h100, 1, 32'h200, 0, 0);
        @(negedge clk); #2; reset = 1'b1; #1;
        model_reset();
        n_total++; if (bus.pc !== 32'h0) $display("FAIL reset_pc: got %h want 0", bus.pc); else n_pass++;
        n_total++; if (bus.halted !== 1'b0) $display("FAIL reset_halted: got %b want 0", bus.halted); else n_pass++;
        fi = bus.flush_ifid; fx = bus.flush_idex;
        n_total++; if ({fi, fx} !== 2'b00) $display("FAIL reset_flush: got %b%b want 00", fi, fx); else n_pass++;
        n_total++; if (bus.taken_count !== 16'd0) $display("FAIL reset_cnt: got %0d want 0", bus.taken_count); else n_pass++;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #3; reset = 1'b0;
        $display("reset: pc=%h halted=%b cnt=%0d", bus.pc, bus.halted, bus.taken_count);
    endtask

    task automatic test_sequential();
        logic fi, fx; bit red;
        n_total++; if (bus.pc !== 32'h0) $display("FAIL seq_start: got %h want 0", bus.pc); else n_pass++;
        for (int i = 1; i <= 5; i++) begin
            drive(0, 0, 32'h0, 0, 32'h0, 0, 0);
            tick(fi, fx, red);
            n_total++; if (bus.pc !== 32'(4 * i)) $display("FAIL seq_pc%0d: got %h want %h", i, bus.pc, 32'(4 * i)); else n_pass++;
            n_total++; if ({fi, fx} !== 2'b00) $display("FAIL seq_flush%0d: got %b%b want 00", i, fi, fx); else n_pass++;
            $display("seq: pc=%h flush=%b%b", bus.pc, fi, fx);
        end
        n_total++; if (bus.pc_plus4 !== 32'd24) $display("FAIL seq_plus4: got %h want 18", bus.pc_plus4); else n_pass++;
        n_total++; if (bus.taken_count !== 16'd0) $display("FAIL seq_cnt: got %0d want 0", bus.taken_count); else n_pass++;
    endtask

    task automatic test_branch_stall();
        logic fi, fx; bit red;
        do_reset();
        for (int i = 0; i < 4; i++) begin drive(0, 0, 0, 0, 0, 0, 0); tick(fi, fx, red); end
        n_total++; if (bus.pc !== 32'h10) $display("FAIL bstall_pre: got %h want 10", bus.pc); else n_pass++;
        drive(1, 1, 32'h40, 0, 32'h0, 1, 0);
        tick(fi, fx, red);
        n_total++; if ({fi, fx} !== 2'b11) $display("FAIL bstall_flush: got %b%b want 11", fi, fx); else n_pass++;
        n_total++; if (bus.pc !== 32'h40) $display("FAIL bstall_pc: got %h want 40", bus.pc); else n_pass++;
        n_total++; if (bus.taken_count !== 16'd1) $display("FAIL bstall_cnt: got %0d want 1", bus.taken_count); else n_pass++;
        $display("branch+stall: pc=%h flush=%b%b cnt=%0d", bus.pc, fi, fx, bus.taken_count);
        // A plain stall holds the PC with no flush.
        drive(0, 0, 32'h0, 0, 32'h0, 1, 0);
        tick(fi, fx, red);
        n_total++; if (bus.pc !== 32'h40 || {fi, fx} !== 2'b00) $display("FAIL stall_hold: got pc=%h fl=%b%b want 40/00", bus.pc, fi, fx); else n_pass++;
    endtask

    task automatic test_not_taken_bubble();
        logic fi, fx; bit red;
        drive(1, 0, 32'h400, 0, 32'h0, 0, 0);
        tick(fi, fx, red);
        n_total++; if (bus.pc !== 32'h44 || {fi, fx} !== 2'b00) $display("FAIL nottaken: got pc=%h fl=%b%b want 44/00", bus.pc, fi, fx); else n_pass++;
        drive(0, 1, 32'h400, 1, 32'h500, 0, 0);
        tick(fi, fx, red);
        n_total++; if (bus.pc !== 32'h48 || {fi, fx} !== 2'b00) $display("FAIL bubble: got pc=%h fl=%b%b want 48/00", bus.pc, fi, fx); else n_pass++;
        n_total++; if (bus.taken_count !== 16'd1) $display("FAIL bubble_cnt: got %0d want 1", bus.taken_count); else n_pass++;
        $display("not-taken/bubble: pc=%h cnt=%0d", bus.pc, bus.taken_count);
    endtask

    task automatic test_jr_priority();
        logic fi, fx; bit red;
        drive(1, 1, 32'h20, 1, 32'h81, 0, 0);
        tick(fi, fx, red);
        n_total++; if (bus.pc !== 32'h80) $display("FAIL jr_pc: got %h want 80", bus.pc); else n_pass++;
        n_total++; if ({fi, fx} !== 2'b11) $display("FAIL jr_flush: got %b%b want 11", fi, fx); else n_pass++;
        n_total++; if (bus.taken_count !== 16'd2) $display("FAIL jr_cnt: got %0d want 2", bus.taken_count); else n_pass++;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick(fi, fx, red);
        n_total++; if ({fi, fx} !== 2'b00 || bus.pc !== 32'h84) $display("FAIL jr_pulse: got fl=%b%b pc=%h want 00/84", fi, fx, bus.pc); else n_pass++;
        $display("jr: pc=%h cnt=%0d", bus.pc, bus.taken_count);
    endtask

    task automatic test_halt_reset();
        logic fi, fx; bit red; logic [15:0] cnt_before;
        drive(1, 1, 32'h24, 0, 0, 0, 0); tick(fi, fx, red);
        drive(0, 0, 0, 0, 0, 0, 1); tick(fi, fx, red);
        n_total++; if (bus.halted !== 1'b1 || bus.pc !== 32'h24) $display("FAIL halt_enter: got h=%b pc=%h want 1/24", bus.halted, bus.pc); else n_pass++;
        cnt_before = bus.taken_count;
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, $urandom, $urandom_range(0, 1), $urandom, $urandom_range(0, 1), $urandom_range(0, 1));
            tick(fi, fx, red);
            n_total++;
            if (bus.pc !== 32'h24 || bus.halted !== 1'b1 || {fi, fx} !== 2'b00)
                $display("FAIL halt_hold%0d: got pc=%h h=%b fl=%b%b want 24/1/00", i, bus.pc, bus.halted, fi, fx);
            else n_pass++;
        end
        n_total++; if (bus.taken_count !== cnt_before) $display("FAIL halt_cnt: got %0d want %0d", bus.taken_count, cnt_before); else n_pass++;
        @(negedge clk); #2; reset = 1'b1; #1;
        model_reset();
        n_total++; if (bus.pc !== 32'h0 || bus.halted !== 1'b0) $display("FAIL halt_reset: got pc=%h h=%b want 0/0", bus.pc, bus.halted); else n_pass++;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #3; reset = 1'b0;
        tick(fi, fx, red);
        n_total++; if (bus.pc !== 32'h4) $display("FAIL post_reset_pc: got %h want 4", bus.pc); else n_pass++;
        drive(1, 1, 32'h60, 0, 0, 0, 1); tick(fi, fx, red);
        n_total++; if (bus.pc !== 32'h60 || bus.halted !== 1'b0 || {fi, fx} !== 2'b11) $display("FAIL halt_redirect: got pc=%h h=%b fl=%b%b want 60/0/11", bus.pc, bus.halted, fi, fx); else n_pass++;
        $display("halt/reset: pc=%h halted=%b", bus.pc, bus.halted);
    endtask

    task automatic test_saturation_wrap();
        logic fi, fx; bit red;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 32'(32'h100 + 16 * i), 0, 0, 0, 0);
            tick(fi, fx, red);
            n_total++; if ({fi, fx} !== 2'b11) $display("FAIL b2b_flush%0d: got %b%b want 11", i, fi, fx); else n_pass++;
        end
        n_total++; if (bus2.taken_count !== 2'd3) $display("FAIL sat_cnt2: got %0d want 3", bus2.taken_count); else n_pass++;
        n_total++; if (bus.taken_count !== 16'd5) $display("FAIL sat_cnt16: got %0d want 5", bus.taken_count); else n_pass++;
        drive(1, 1, 32'hFFFF_FFFC, 0, 0, 0, 0); tick(fi, fx, red);
        n_total++; if (bus.pc_plus4 !== 32'h0) $display("FAIL wrap_plus4: got %h want 0", bus.pc_plus4); else n_pass++;
        drive(0, 0, 0, 0, 0, 0, 0); tick(fi, fx, red);
        n_total++; if (bus.pc !== 32'h0) $display("FAIL wrap_pc: got %h want 0", bus.pc); else n_pass++;
        n_total++; if (bus2.taken_count !== 2'd3) $display("FAIL sat_hold: got %0d want 3", bus2.taken_count); else n_pass++;
        $display("sat/wrap: pc=%h cnt16=%0d cnt2=%0d", bus.pc, bus.taken_count, bus2.taken_count);
    endtask

    task automatic test_random();
        logic fi, fx; bit red;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            if (m_halt && $urandom_range(0, 3) == 0) do_reset();
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom,
                  $urandom_range(0, 5) == 0, $urandom, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 19) == 0);
            tick(fi, fx, red);
            n_total++;
            if (fi !== red || fx !== red || bus.pc !== m_pc || bus.halted !== m_halt ||
                bus.taken_count !== 16'(m_cnt) || bus2.taken_count !== 2'(m_cnt2) || bus2.pc !== m_pc)
                $display("FAIL rand%0d: got pc=%h fl=%b%b h=%b c=%0d c2=%0d want pc=%h fl=%b h=%b c=%0d c2=%0d",
                         i, bus.pc, fi, fx, bus.halted, bus.taken_count, bus2.taken_count,
                         m_pc, red, m_halt, m_cnt, m_cnt2);
            else n_pass++;
            $display("rand%0d: pc=%h fl=%b halted=%b cnt=%0d", i, bus.pc, fi, bus.halted, bus.taken_count);
        end
    endtask

    initial begin
        bus.stall = 0; bus.ex_valid = 0; bus.branch_or_not = 0; bus.branch_target = '0;
        bus.jr = 0; bus.jr_target = '0; bus.halt = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #3; reset = 1'b0;
        test_reset();
        test_sequential();
        test_branch_stall();
        test_not_taken_bubble();
        test_jr_priority();
        test_halt_reset();
        test_saturation_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end
endmodule
